// File: rtl/display_cronometro.sv
// display_cronometro: five-digit multiplexed 7-segment driver showing M.SS.CC
// Ports: clk; reset_display (async, active-high); display_enable (0 blanks digits, scan continues);
//   minutos/segundos/centesimas (binary time, clamped to 9/59/99 at frame start);
//   an (digit selects: an[0]=C ones, an[1]=C tens, an[2]=S ones, an[3]=S tens, an[4]=M);
//   seg {g,f,e,d,c,b,a}; dp. ACTIVE_LOW=1 makes an/seg/dp active-low.
// Optional: define CRONO_LEADING_ZERO_BLANK_EN to blank the minutes digit when zero
//   and the seconds-tens digit when minutes and seconds-tens are both zero.
module display_cronometro #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int SCAN_FREQ = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_display,
  input  logic       display_enable,
  input  logic [3:0] minutos,
  input  logic [5:0] segundos,
  input  logic [6:0] centesimas,
  output logic [4:0] an,
  output logic [6:0] seg,
  output logic       dp
);
  localparam int DIV = CLK_FREQ / SCAN_FREQ;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  logic [PW-1:0] pre;
  logic [2:0] idx;
  logic live, tick, lit, blank;
  logic [3:0] snap_m, s_t, s_o, c_t, c_o, dig;
  logic [5:0] snap_s;
  logic [6:0] snap_c;
  logic [4:0] an_hi;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction
  assign tick = pre == PW'(DIV - 1);
  assign s_t = 4'(snap_s / 6'd10);
  assign s_o = 4'(snap_s % 6'd10);
  assign c_t = 4'(snap_c / 7'd10);
  assign c_o = 4'(snap_c % 7'd10);
  // live stays low until the first digit advance, so the display is dark for the first slot after reset
  assign lit = display_enable && live;
  always_comb begin
    dig = idx == 3'd0 ? c_o : idx == 3'd1 ? c_t : idx == 3'd2 ? s_o : idx == 3'd3 ? s_t : snap_m;
`ifdef CRONO_LEADING_ZERO_BLANK_EN
    blank = snap_m == 4'd0 && (idx == 3'd4 || (idx == 3'd3 && s_t == 4'd0));
`else
    blank = 1'b0;
`endif
    an_hi = lit ? 5'(5'b1 << idx) : 5'b0;
  end
  always_ff @(posedge clk or posedge reset_display) begin
    if (reset_display) begin
      pre <= '0;
      idx <= 3'd0;
      live <= 1'b0;
      snap_m <= 4'd0;
      snap_s <= 6'd0;
      snap_c <= 7'd0;
      an <= {5{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp <= ACTIVE_LOW;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        idx <= idx == 3'd4 ? 3'd0 : idx + 3'd1;
        live <= 1'b1;
        // frame start: latch a coherent, clamped copy of the time
        if (idx == 3'd4) begin
          snap_m <= minutos > 4'd9 ? 4'd9 : minutos;
          snap_s <= segundos > 6'd59 ? 6'd59 : segundos;
          snap_c <= centesimas > 7'd99 ? 7'd99 : centesimas;
        end
      end
      an <= an_hi ^ {5{ACTIVE_LOW}};
      seg <= ((lit && !blank) ? seg7(dig) : 7'h00) ^ {7{ACTIVE_LOW}};
      dp <= (lit && (idx == 3'd2 || idx == 3'd4)) ^ ACTIVE_LOW;
    end
  end
endmodule

// File: tb/tb_display_cronometro.sv
// tb_display_cronometro: directed table-driven checks of the M.SS.CC scan driver (DIV=10)
module tb_display_cronometro;
`ifdef CRONO_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [6:0] Z_LEAD = LZB ? 7'h00 : 7'h3F;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [3:0] m = 4'd0;
  logic [5:0] s = 6'd0;
  logic [6:0] c = 7'd0;
  logic [4:0] an;
  logic [6:0] seg;
  logic dp;
  int k = 0, checks = 0, errors = 0;
  typedef struct {
    logic [3:0] m;
    logic [5:0] s;
    logic [6:0] c;
    logic [4:0][6:0] e;
  } vec_t;
  vec_t tbl [4];
  display_cronometro #(.CLK_FREQ(1000), .SCAN_FREQ(100), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset_display(rst), .display_enable(en),
    .minutos(m), .segundos(s), .centesimas(c),
    .an(an), .seg(seg), .dp(dp)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) k <= rst ? 0 : k + 1;
  task automatic wait_k(input int t);
    while (k < t) @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [4:0] ea, input logic [6:0] es, input logic ed);
    checks++;
    if (an !== ea || seg !== es || dp !== ed) begin
      errors++;
      $display("FAIL %s k=%0d got an=%b seg=%h dp=%b expected an=%b seg=%h dp=%b", nm, k, an, seg, dp, ea, es, ed);
    end
  endtask
  task automatic chk_off(input string nm);
    chk(nm, 5'b11111, 7'h7F, 1'b1);
  endtask
  task automatic chkd(input string nm, input int d, input logic [6:0] code);
    logic [4:0] one;
    one = 5'(5'b1 << d);
    chk(nm, ~one, ~code, !(d == 2 || d == 4));
  endtask
  initial begin
    tbl[0] = '{4'd3, 6'd47, 7'd58, {7'h4F, 7'h66, 7'h07, 7'h6D, 7'h7F}};
    tbl[1] = '{4'd12, 6'd63, 7'd120, {7'h6F, 7'h6D, 7'h6F, 7'h6F, 7'h6F}};
    tbl[2] = '{4'd0, 6'd5, 7'd7, {Z_LEAD, Z_LEAD, 7'h6D, 7'h3F, 7'h07}};
    tbl[3] = '{4'd9, 6'd10, 7'd99, {7'h6F, 7'h06, 7'h3F, 7'h6F, 7'h6F}};
    repeat (3) @(negedge clk);
    chk_off("in_reset");
    rst = 1'b0;
    chk_off("reset_k0");
    wait_k(10); chk_off("pre_tick");
    wait_k(11); chkd("scan_d1", 1, 7'h3F);
    wait_k(21); chkd("scan_d2", 2, 7'h3F);
    wait_k(31); chkd("scan_d3", 3, Z_LEAD);
    wait_k(41); chkd("scan_d4", 4, Z_LEAD);
    for (int i = 0; i < 4; i++) begin
      wait_k(50 * (i + 1) - 5);
      m = tbl[i].m; s = tbl[i].s; c = tbl[i].c;
      for (int d = 0; d < 5; d++) begin
        wait_k(50 * (i + 1) + 5 + 10 * d);
        chkd($sformatf("vec%0d_d%0d", i, d), d, tbl[i].e[d]);
      end
    end
    wait_k(245); m = 4'd2; s = 6'd30; c = 7'd58;
    wait_k(255); chkd("mid_old_d0", 0, 7'h7F);
    wait_k(265); chkd("mid_old_d1", 1, 7'h6D);
    c = 7'd59; s = 6'd41;
    wait_k(275); chkd("mid_hold_d2", 2, 7'h3F);
    wait_k(285); chkd("mid_hold_d3", 3, 7'h4F);
    wait_k(295); chkd("mid_hold_d4", 4, 7'h5B);
    wait_k(305); chkd("mid_new_d0", 0, 7'h6F);
    wait_k(325); chkd("mid_new_d2", 2, 7'h06);
    wait_k(335); chkd("mid_new_d3", 3, 7'h66);
    wait_k(345); m = 4'd1; s = 6'd2; c = 7'd3;
    wait_k(350); en = 1'b0;
    for (int t = 355; t <= 445; t += 10) begin
      wait_k(t);
      chk_off($sformatf("disabled_k%0d", t));
    end
    en = 1'b1;
    wait_k(446); chkd("reen_d4", 4, 7'h06);
    wait_k(455); chkd("reen_d0", 0, 7'h4F);
    wait_k(465); chkd("reen_d1", 1, 7'h3F);
    wait_k(485);
    #2 rst = 1'b1;
    #1 chk_off("async_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_off("rerel_k0");
    wait_k(11); chkd("rerel_d1", 1, 7'h3F);
    wait_k(31); chkd("rerel_d3", 3, Z_LEAD);
    wait_k(41); chkd("rerel_d4", 4, Z_LEAD);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
